serial_subtractor: RTL and testbench

//   Bit-serial 4-bit subtractor: computes Switch - Key one bit per clock,
//   LSB first, using a single full-subtractor cell and a borrow flip-flop.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start handshake,
// switch/key operands, LED difference, borrow and busy/done status.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] Switch;
  logic [WIDTH-1:0] Key;
  logic [WIDTH-1:0] LED;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, Switch, Key,
    input  LED, borrow, busy, done
  );

  modport slave (
    input  start, Switch, Key,
    output LED, borrow, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial Switch - Key, LSB first, through one full-subtractor cell and a
// borrow flop; result lands on LED/borrow together with a one-cycle done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             diff_s;
  logic             br_nxt_s;
  logic             busy_s;
  logic             done_s;

  // State and datapath registers; rst wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_SHIFT;
        else           state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
        else                   state_d = ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff_s   = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Datapath update; the result registers load on the last SHIFT edge so
  // LED/borrow are already valid during the DONE cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    led_d    = led_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d   = bus.Switch;
          b_d   = bus.Key;
          sh_d  = '0;
          cnt_d = '0;
          br_d  = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sh_d  = {diff_s, sh_q[WIDTH-1:1]};
        br_d  = br_nxt_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          led_d    = {diff_s, sh_q[WIDTH-1:1]};
          borrow_d = br_nxt_s;
        end else begin
          led_d = led_q;
        end
      end
      ST_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Status decode straight from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_IDLE:  begin busy_s = 1'b0; done_s = 1'b0; end
      ST_SHIFT: begin busy_s = 1'b1; done_s = 1'b0; end
      ST_DONE:  begin busy_s = 1'b0; done_s = 1'b1; end
      default:  begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  assign bus.LED    = led_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_s;
  assign bus.done   = done_s;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: reset state, spec vectors, latency,
// operand latching, mid-run reset, back-to-back starts and all 256 pairs.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   lat;
  int   done_seen;
  int   period;

  serial_subtractor_if #(.WIDTH(4)) bus_if ();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int cycles);
    @(negedge clk);
    bus_if.Switch = a;
    bus_if.Key    = b;
    bus_if.start  = 1'b1;
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.Switch = 4'd0;
    bus_if.Key    = 4'd0;
    repeat (3) @(negedge clk);

    check_eq("rst_led",    {28'd0, bus_if.LED}, 32'd0);
    check_eq("rst_borrow", {31'd0, bus_if.borrow}, 32'd0);
    check_eq("rst_busy",   {31'd0, bus_if.busy}, 32'd0);
    check_eq("rst_done",   {31'd0, bus_if.done}, 32'd0);
    rst = 1'b0;

    // 9-3 with cycle-accurate busy/done profile
    @(negedge clk);
    bus_if.Switch = 4'd9;
    bus_if.Key    = 4'd3;
    bus_if.start  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      check_eq("lat_busy", {31'd0, bus_if.busy}, 32'd1);
      check_eq("lat_nodone", {31'd0, bus_if.done}, 32'd0);
    end
    @(negedge clk);
    check_eq("lat_done",   {31'd0, bus_if.done}, 32'd1);
    check_eq("lat_nobusy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("9m3_led",    {28'd0, bus_if.LED}, 32'd6);
    check_eq("9m3_borrow", {31'd0, bus_if.borrow}, 32'd0);
    @(negedge clk);
    check_eq("done_pulse", {31'd0, bus_if.done}, 32'd0);
    check_eq("led_hold",   {28'd0, bus_if.LED}, 32'd6);

    run_op(4'd3, 4'd9, lat);
    check_eq("3m9_lat", lat, 32'd5);
    check_eq("3m9_led", {28'd0, bus_if.LED}, 32'd10);
    check_eq("3m9_borrow", {31'd0, bus_if.borrow}, 32'd1);
    run_op(4'd0, 4'd0, lat);
    check_eq("0m0_led", {28'd0, bus_if.LED}, 32'd0);
    check_eq("0m0_borrow", {31'd0, bus_if.borrow}, 32'd0);
    run_op(4'd15, 4'd15, lat);
    check_eq("fmf_led", {28'd0, bus_if.LED}, 32'd0);
    check_eq("fmf_borrow", {31'd0, bus_if.borrow}, 32'd0);
    run_op(4'd0, 4'd15, lat);
    check_eq("0mf_led", {28'd0, bus_if.LED}, 32'd1);
    check_eq("0mf_borrow", {31'd0, bus_if.borrow}, 32'd1);

    // Operands change and start re-pulses mid-SHIFT: must be ignored
    @(negedge clk);
    bus_if.Switch = 4'd7;
    bus_if.Key    = 4'd2;
    bus_if.start  = 1'b1;
    done_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) bus_if.start = 1'b0;
      if (i == 2) begin
        bus_if.Switch = 4'd15;
        bus_if.Key    = 4'd0;
        bus_if.start  = 1'b1;
      end
      if (i == 3) bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) begin
        done_seen++;
        check_eq("latch_led", {28'd0, bus_if.LED}, 32'd5);
        check_eq("latch_borrow", {31'd0, bus_if.borrow}, 32'd0);
      end
    end
    check_eq("latch_one_done", done_seen, 32'd1);
    check_eq("latch_idle", {31'd0, bus_if.busy}, 32'd0);

    // Reset in the 2nd SHIFT cycle aborts without a done pulse
    @(negedge clk);
    bus_if.Switch = 4'd8;
    bus_if.Key    = 4'd1;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_led", {28'd0, bus_if.LED}, 32'd0);
    check_eq("abort_borrow", {31'd0, bus_if.borrow}, 32'd0);
    check_eq("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 32'd0);
    run_op(4'd8, 4'd1, lat);
    check_eq("8m1_led", {28'd0, bus_if.LED}, 32'd7);

    // rst and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1;
    bus_if.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.start = 1'b0;
    check_eq("rst_prio_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("rst_prio_led", {28'd0, bus_if.LED}, 32'd0);

    // start held high: back-to-back period is WIDTH+2
    @(negedge clk);
    bus_if.Switch = 4'd6;
    bus_if.Key    = 4'd1;
    bus_if.start  = 1'b1;
    done_seen = 0;
    period = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done_seen == 1) period++;
      if (bus_if.done === 1'b1) begin
        done_seen++;
        if (done_seen == 2) break;
      end
    end
    bus_if.start = 1'b0;
    check_eq("b2b_period", period, 32'd6);
    check_eq("b2b_led", {28'd0, bus_if.LED}, 32'd5);
    repeat (8) @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), lat);
        check_eq("exh_led", {28'd0, bus_if.LED}, 32'((a - b) & 15));
        check_eq("exh_borrow", {31'd0, bus_if.borrow}, (a < b) ? 32'd1 : 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
